sim_mem_trace_capture: RTL and testbench
========================================

// Module: sim_mem_trace_capture
// PURPOSE
// - Passive per-lane monitor that snoops request (or response) handshakes on a
//   NUM_LANES-wide memory interface and feeds the simulation trace logger
//   directly downstream.
// - Every fire (valid & ready) is buffered in a per-lane FIFO.
// - Buffered entries are presented as one lane-parallel bundle, so logger
//   backpressure never stalls or perturbs the monitored interface.
// - Overflow is counted per lane, never silently lost.
// PARAMETERS
// - NUM_LANES    4  lanes monitored; lane 0 sits at the LSB of every packed bus
// - FIFO_DEPTH   4  entries per lane FIFO; power of two, >= 2
// - CNT_W       16  width of each per-lane saturating drop counter
// PORTS
// - clock               in   1                    single clock domain
// - reset               in   1                    async assert, active-low (0 = reset)
// - trace_enable        in   1                    1 = capture fires; 0 = capture off, drain continues
// - mon_valid           in   NUM_LANES            snooped valid per lane
// - mon_ready           in   NUM_LANES            snooped ready per lane (observed only)
// - mon_source          in   SRC_W*NUM_LANES      snooped source id
// - mon_address         in   DATA_W*NUM_LANES     snooped address
// - mon_is_store        in   NUM_LANES            snooped store flag
// - mon_size            in   LOGSIZE_W*NUM_LANES  snooped log2 size
// - mon_data            in   DATA_W*NUM_LANES     snooped data
// - trace_log_valid     out  NUM_LANES            lane FIFO non-empty
// - trace_log_source    out  SRC_W*NUM_LANES      head entry fields, same packing as mon_*
// - trace_log_address   out  DATA_W*NUM_LANES     head entry address
// - trace_log_is_store  out  NUM_LANES            head entry store flag
// - trace_log_size      out  LOGSIZE_W*NUM_LANES  head entry log2 size
// - trace_log_data      out  DATA_W*NUM_LANES     head entry data
// - trace_log_ready     in   1                    logger accepts the bundle this cycle
// - drop_count          out  CNT_W*NUM_LANES      per-lane dropped-fire count
// - overflow            out  1                    sticky; OR of all lanes ever dropping
// BEHAVIOUR
// - Reset (reset==0, async)
//   - All FIFOs empty, all trace_log_valid 0, drop_count 0, overflow 0.
//   - Data outputs are 0 while empty.
//   - Reset mid-drain discards all buffered entries; no partial bundle survives.
// - Enqueue
//   - lane l enqueues when trace_enable & mon_valid[l] & mon_ready[l].
//   - All fields are captured on the same clock edge.
// - Latency: exactly 1 cycle, fire in cycle N -> trace_log_valid[l]=1 in cycle N+1.
//   There is no combinational bypass.
// - Dequeue
//   - When trace_log_ready==1, every lane whose trace_log_valid is 1 pops its
//     head on that edge; lanes are lockstep on ready.
//   - When trace_log_ready==0, heads and valid hold stable.
// - Valid/ready
//   - trace_log_valid is never gated by trace_log_ready.
//   - Once asserted, valid stays high until the entry pops.
// - Full FIFO
//   - Enqueue and dequeue in the same cycle: the enqueue is accepted and
//     occupancy is unchanged.
//   - Full FIFO without dequeue: the fire is dropped, drop_count[l] increments
//     (saturates at all-ones, no wrap), and overflow sets, stuck until reset.
// - Empty FIFO with enqueue and ready in the same cycle: no pop, because valid
//   was 0; the new entry appears next cycle.
// - Pointers
//   - Read/write pointers are log2(FIFO_DEPTH)+1 bits; the MSB disambiguates
//     full from empty, and wrap-around is natural modulo.
// - trace_enable falling
//   - Takes effect the same cycle: a fire coincident with enable==0 is not
//     captured and not counted as a drop.
// - Ordering: per-lane FIFO order equals fire order; there is no ordering
//   guarantee across lanes.
// STRUCTURE
// - simmem_pkg
//   - Constants SRC_W, DATA_W (64), LOGSIZE_W, matching the SIMMEM_* defines.
//   - typedef struct packed {source, address, is_store, size, data}
//     trace_entry_t.
// - Sub-module mem_trace_lane_fifo (one per lane, generate loop)
//   - Interface: trace_entry_t in/out, push, pop, full, empty, async active-low
//     reset.
//   - Owns the pointers; storage is a flop array (no SRAM).
// - Top level: pack/unpack buses, drop counters, sticky overflow, fan-out of
//   trace_log_ready to every lane pop.
// TESTING
// - T1 single fire:
//   - Stimulus: lane 2 fires addr 0x1000, src 3, store, size 2, data 0xAB,
//     ready=1.
//   - Required: next cycle trace_log_valid=4'b0100 with those exact fields;
//     cycle after, valid=0.
// - T2 backpressure:
//   - Stimulus: ready=0; lane 0 fires 3 times (addr 0x0, 0x8, 0x10).
//   - Required: valid held, head=0x0; then ready=1 -> heads 0x8, 0x10 on
//     successive cycles; then empty.
// - T3 overflow:
//   - Stimulus: FIFO_DEPTH=4, ready=0, lane 1 fires 6 times.
//   - Required: drop_count[1]=2, overflow=1, drained entries are the first 4
//     in order.
// - T4 full + simultaneous pop:
//   - Stimulus: lane 3 full; fire and ready=1 in the same cycle.
//   - Required: no drop, occupancy stays 4, new entry appears last.
// - T5 enable gating:
//   - Stimulus: trace_enable=0 during 5 fires on all lanes.
//   - Required: valid=0, drop_count=0 throughout; re-enable -> next fire
//     captured.
// - T6 async reset mid-drain:
//   - Stimulus: assert reset between edges with 3 entries buffered.
//   - Required: valid=0 immediately (before next edge); after release, no
//     stale entries.

Source files
------------

// File: rtl/simmem_pkg.sv
// Shared widths and the trace entry layout for the simulated-memory trace path.
// Field order in trace_entry_t mirrors the monitored bus signal order.
package simmem_pkg;
    localparam int SRC_W     = 8;
    localparam int DATA_W    = 64;
    localparam int LOGSIZE_W = 3;

    typedef struct packed {
        logic [SRC_W-1:0]     source;
        logic [DATA_W-1:0]    address;
        logic                 is_store;
        logic [LOGSIZE_W-1:0] size;
        logic [DATA_W-1:0]    data;
    } trace_entry_t;
endpackage

// File: rtl/mem_trace_lane_fifo.sv
// One lane's trace buffer: flop-array FIFO with extra-MSB pointers.
// The head reads as zero while empty so the logger never sees stale fields.
module mem_trace_lane_fifo
    import simmem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  trace_entry_t din,
    input  logic         pop,
    output trace_entry_t dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    trace_entry_t mem [DEPTH];

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop && !empty) rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset: reads are masked while empty.
    always_ff @(posedge clock) begin
        if (push) mem[wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/sim_mem_trace_capture.sv
// Passive lane-parallel monitor: buffers every fire per lane for the trace
// logger, counting fires lost to a full buffer instead of stalling the bus.
module sim_mem_trace_capture
    import simmem_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           trace_enable,
    input  logic [NUM_LANES-1:0]           mon_valid,
    input  logic [NUM_LANES-1:0]           mon_ready,
    input  logic [SRC_W*NUM_LANES-1:0]     mon_source,
    input  logic [DATA_W*NUM_LANES-1:0]    mon_address,
    input  logic [NUM_LANES-1:0]           mon_is_store,
    input  logic [LOGSIZE_W*NUM_LANES-1:0] mon_size,
    input  logic [DATA_W*NUM_LANES-1:0]    mon_data,
    output logic [NUM_LANES-1:0]           trace_log_valid,
    output logic [SRC_W*NUM_LANES-1:0]     trace_log_source,
    output logic [DATA_W*NUM_LANES-1:0]    trace_log_address,
    output logic [NUM_LANES-1:0]           trace_log_is_store,
    output logic [LOGSIZE_W*NUM_LANES-1:0] trace_log_size,
    output logic [DATA_W*NUM_LANES-1:0]    trace_log_data,
    input  logic                           trace_log_ready,
    output logic [CNT_W*NUM_LANES-1:0]     drop_count,
    output logic                           overflow
);
    logic [NUM_LANES-1:0] drop_vec;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        trace_entry_t     din;
        trace_entry_t     dout;
        logic             full, empty, fire, pop, push, drop;
        logic [CNT_W-1:0] cnt;

        assign din = '{source:   mon_source[l*SRC_W +: SRC_W],
                       address:  mon_address[l*DATA_W +: DATA_W],
                       is_store: mon_is_store[l],
                       size:     mon_size[l*LOGSIZE_W +: LOGSIZE_W],
                       data:     mon_data[l*DATA_W +: DATA_W]};

        assign fire = trace_enable & mon_valid[l] & mon_ready[l];
        assign pop  = trace_log_ready & ~empty;
        // A full lane still accepts when its head leaves on the same edge.
        assign push = fire & (~full | pop);
        assign drop = fire & full & ~pop;
        assign drop_vec[l] = drop;

        mem_trace_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (push),
            .din   (din),
            .pop   (pop),
            .dout  (dout),
            .full  (full),
            .empty (empty)
        );

        always_ff @(posedge clock or negedge reset) begin
            if (!reset)                 cnt <= '0;
            else if (drop && cnt != '1) cnt <= cnt + 1'b1;
        end

        assign trace_log_valid[l]                           = ~empty;
        assign trace_log_source[l*SRC_W +: SRC_W]           = dout.source;
        assign trace_log_address[l*DATA_W +: DATA_W]        = dout.address;
        assign trace_log_is_store[l]                        = dout.is_store;
        assign trace_log_size[l*LOGSIZE_W +: LOGSIZE_W]     = dout.size;
        assign trace_log_data[l*DATA_W +: DATA_W]           = dout.data;
        assign drop_count[l*CNT_W +: CNT_W]                 = cnt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)         overflow <= 1'b0;
        else if (|drop_vec) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_sim_mem_trace_capture.sv
// Scoreboard bench: per-lane expected-entry queues filled on fires, popped on
// logger handshakes, and compared against the head bundle every cycle.
module tb_sim_mem_trace_capture;
    import simmem_pkg::*;

    localparam int NL = 4;
    localparam int DEPTH = 4;
    localparam int CW = 16;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    trace_enable;
    logic [NL-1:0]           mon_valid, mon_ready, mon_is_store;
    logic [SRC_W*NL-1:0]     mon_source;
    logic [DATA_W*NL-1:0]    mon_address, mon_data;
    logic [LOGSIZE_W*NL-1:0] mon_size;
    logic [NL-1:0]           trace_log_valid, trace_log_is_store;
    logic [SRC_W*NL-1:0]     trace_log_source;
    logic [DATA_W*NL-1:0]    trace_log_address, trace_log_data;
    logic [LOGSIZE_W*NL-1:0] trace_log_size;
    logic                    trace_log_ready;
    logic [CW*NL-1:0]        drop_count;
    logic                    overflow;

    sim_mem_trace_capture #(.NUM_LANES(NL), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .trace_enable(trace_enable),
        .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_source(mon_source),
        .mon_address(mon_address), .mon_is_store(mon_is_store), .mon_size(mon_size),
        .mon_data(mon_data), .trace_log_valid(trace_log_valid),
        .trace_log_source(trace_log_source), .trace_log_address(trace_log_address),
        .trace_log_is_store(trace_log_is_store), .trace_log_size(trace_log_size),
        .trace_log_data(trace_log_data), .trace_log_ready(trace_log_ready),
        .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    trace_entry_t   sb_q [NL][$];
    trace_entry_t   fld  [NL];
    logic [CW-1:0]  exp_drop [NL];
    logic           exp_ovf;
    int             seq = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int l, input logic [7:0] src, input logic [63:0] addr,
                            input logic st, input logic [2:0] sz, input logic [63:0] d);
        fld[l] = '{source: src, address: addr, is_store: st, size: sz, data: d};
    endtask

    task automatic auto_fields();
        for (int l = 0; l < NL; l++) begin
            seq++;
            set_lane(l, 8'(seq * 7 + l), 64'h100 * seq + 64'(l), seq[0], 3'(seq + l),
                     {32'hD00D0000, 32'(seq)} ^ 64'(l << 40));
        end
    endtask

    task automatic clear_model();
        for (int l = 0; l < NL; l++) begin
            sb_q[l].delete();
            exp_drop[l] = '0;
        end
        exp_ovf = 1'b0;
    endtask

    task automatic check_outputs();
        logic [NL-1:0] ev;
        for (int l = 0; l < NL; l++) begin
            ev[l] = (sb_q[l].size() != 0);
            check($sformatf("drop_count[%0d]", l), 64'(drop_count[l*CW +: CW]), 64'(exp_drop[l]));
            if (ev[l]) begin
                check($sformatf("addr[%0d]", l), trace_log_address[l*DATA_W +: DATA_W], sb_q[l][0].address);
                check($sformatf("data[%0d]", l), trace_log_data[l*DATA_W +: DATA_W], sb_q[l][0].data);
                check($sformatf("meta[%0d]", l),
                      64'({trace_log_source[l*SRC_W +: SRC_W], trace_log_is_store[l],
                           trace_log_size[l*LOGSIZE_W +: LOGSIZE_W]}),
                      64'({sb_q[l][0].source, sb_q[l][0].is_store, sb_q[l][0].size}));
            end else begin
                check($sformatf("idle_addr[%0d]", l), trace_log_address[l*DATA_W +: DATA_W], 64'h0);
                check($sformatf("idle_data[%0d]", l), trace_log_data[l*DATA_W +: DATA_W], 64'h0);
            end
        end
        check("valid", 64'(trace_log_valid), 64'(ev));
        check("overflow", 64'(overflow), 64'(exp_ovf));
    endtask

    // One clock: check state left by the previous edge, drive, advance model.
    task automatic step(input logic en, input logic [NL-1:0] vm, input logic [NL-1:0] rm,
                        input logic lr);
        @(negedge clock);
        check_outputs();
        trace_enable = en; mon_valid = vm; mon_ready = rm; trace_log_ready = lr;
        for (int l = 0; l < NL; l++) begin
            mon_source[l*SRC_W +: SRC_W]         = fld[l].source;
            mon_address[l*DATA_W +: DATA_W]      = fld[l].address;
            mon_is_store[l]                      = fld[l].is_store;
            mon_size[l*LOGSIZE_W +: LOGSIZE_W]   = fld[l].size;
            mon_data[l*DATA_W +: DATA_W]         = fld[l].data;
        end
        for (int l = 0; l < NL; l++) begin
            bit full_now = (sb_q[l].size() == DEPTH);
            bit pop_now  = lr && (sb_q[l].size() != 0);
            bit fire     = en && vm[l] && rm[l];
            if (pop_now) void'(sb_q[l].pop_front());
            if (fire) begin
                if (!full_now || pop_now) sb_q[l].push_back(fld[l]);
                else begin
                    if (exp_drop[l] != '1) exp_drop[l]++;
                    exp_ovf = 1'b1;
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0; trace_enable = 1'b0; mon_valid = '0; mon_ready = '0;
        mon_source = '0; mon_address = '0; mon_is_store = '0; mon_size = '0;
        mon_data = '0; trace_log_ready = 1'b0;
        for (int l = 0; l < NL; l++) set_lane(l, 8'h0, 64'h0, 1'b0, 3'h0, 64'h0);
        clear_model();
        #12;
        check_outputs();
        @(negedge clock) reset = 1'b1;

        // T1 single fire on lane 2
        set_lane(2, 8'd3, 64'h1000, 1'b1, 3'd2, 64'hAB);
        step(1, 4'b0100, 4'b0100, 1);
        step(1, 4'b0000, 4'b0000, 1);
        step(1, 4'b0000, 4'b0000, 1);

        // T2 backpressure on lane 0
        set_lane(0, 8'd1, 64'h0, 1'b0, 3'd3, 64'h11); step(1, 4'b0001, 4'b0001, 0);
        set_lane(0, 8'd1, 64'h8, 1'b0, 3'd3, 64'h22); step(1, 4'b0001, 4'b0001, 0);
        set_lane(0, 8'd1, 64'h10, 1'b0, 3'd3, 64'h33); step(1, 4'b0001, 4'b0001, 0);
        step(1, 4'b0000, 4'b0000, 0);
        check("t2_head", trace_log_address[63:0], 64'h0);
        repeat (4) step(1, 4'b0000, 4'b0000, 1);

        // T3 overflow on lane 1: six fires into four slots
        for (int i = 0; i < 6; i++) begin
            auto_fields();
            step(1, 4'b0010, 4'b0010, 0);
        end
        step(1, 4'b0000, 4'b0000, 0);
        check("t3_drop1", 64'(drop_count[CW +: CW]), 64'd2);
        check("t3_ovf", 64'(overflow), 64'd1);
        repeat (5) step(1, 4'b0000, 4'b0000, 1);

        // T4 lane 3 full, fire with simultaneous pop
        for (int i = 0; i < 4; i++) begin
            auto_fields();
            step(1, 4'b1000, 4'b1000, 0);
        end
        set_lane(3, 8'h5A, 64'hBEEF, 1'b1, 3'd1, 64'hCAFE);
        step(1, 4'b1000, 4'b1000, 1);
        step(1, 4'b0000, 4'b0000, 0);
        check("t4_drop3", 64'(drop_count[3*CW +: CW]), 64'd0);
        repeat (5) step(1, 4'b0000, 4'b0000, 1);

        // T5 enable gating, then re-enable
        for (int i = 0; i < 5; i++) begin
            auto_fields();
            step(0, 4'b1111, 4'b1111, 1);
        end
        auto_fields();
        step(1, 4'b0001, 4'b0001, 0);
        step(1, 4'b0000, 4'b0000, 1);

        // Mixed random traffic
        for (int i = 0; i < 60; i++) begin
            auto_fields();
            step(($urandom_range(0, 7) != 0), 4'($urandom), 4'($urandom),
                 ($urandom_range(0, 2) == 0));
        end
        repeat (6) step(1, 4'b0000, 4'b0000, 1);

        // T6 async reset mid-drain with three entries buffered
        for (int i = 0; i < 3; i++) begin
            auto_fields();
            step(1, 4'b0001, 4'b0001, 0);
        end
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("t6_valid_async", 64'(trace_log_valid), 64'h0);
        check("t6_addr_async", trace_log_address[63:0], 64'h0);
        clear_model();
        mon_valid = '0; trace_log_ready = 1'b0;
        @(negedge clock) reset = 1'b1;
        repeat (3) step(1, 4'b0000, 4'b0000, 1);
        auto_fields();
        step(1, 4'b0100, 4'b0100, 1);
        repeat (2) step(1, 4'b0000, 4'b0000, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
